// File: rtl/branch_predict_unit_pkg.sv
// Shared CPU package for the branch predictor.
// Holds the 2-bit counter encodings and the index-width helper.
// Both the top level and the counter sub-module import it.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,   // strongly not-taken
        CNT_WNT = 2'd1,   // weakly not-taken
        CNT_WT  = 2'd2,   // weakly taken
        CNT_ST  = 2'd3    // strongly taken
    } cnt_state_e;

    // Number of PC bits used to index a table of 'depth' entries.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// sat_counter2: next-state function of one 2-bit saturating predictor counter.
// Ports:
//   cnt_cur  in   current counter state of the entry being updated
//   hit      in   entry is valid and its tag matches (otherwise it is allocated)
//   taken    in   resolved direction
//   is_jump  in   resolving instruction is an unconditional jump
//   cnt_nxt  out  counter state to write back
module sat_counter2
    import branch_predict_unit_pkg::*;
(
    input  cnt_state_e cnt_cur,
    input  logic       hit,
    input  logic       taken,
    input  logic       is_jump,
    output cnt_state_e cnt_nxt
);

    logic [1:0] cnt_raw;

    always_comb begin
        cnt_raw = cnt_cur;
        if (is_jump) begin
            cnt_raw = CNT_ST;
        end else if (!hit) begin
            // Fresh allocation starts on the weak side of the observed direction.
            cnt_raw = taken ? CNT_WT : CNT_WNT;
        end else if (taken) begin
            if (cnt_cur != CNT_ST) cnt_raw = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != CNT_SNT) cnt_raw = cnt_cur - 2'd1;
        end
        cnt_nxt = cnt_state_e'(cnt_raw);
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch target buffer with 2-bit
// saturating direction counters, resolve-side mispredict detection and a
// saturating mispredict statistics counter.
// Ports:
//   clk, arst_n            clock (rising edge), async active-low reset
//   if_pc                  fetch PC; pred_taken / pred_pc are its combinational prediction
//   ex_valid .. ex_pred_pc resolving instruction and the prediction it carried
//   redirect / redirect_pc combinational flush request and the correct next PC
//   mispredict_cnt         saturating count of cycles with redirect asserted
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [DATA_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_pc,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [31:0]       ex_instr,
    input  logic [DATA_W-1:0] ex_branch_offset,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    input  logic [DATA_W-1:0] ex_pred_pc,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = idx_width(BHT_DEPTH);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    logic              valid_q  [BHT_DEPTH];
    logic              valid_d  [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_d    [BHT_DEPTH];
    logic [DATA_W-1:0] target_q [BHT_DEPTH];
    logic [DATA_W-1:0] target_d [BHT_DEPTH];
    cnt_state_e        cnt_q    [BHT_DEPTH];
    cnt_state_e        cnt_d    [BHT_DEPTH];
    logic [CNT_W-1:0]  mcnt_q, mcnt_d;

    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic [DATA_W-1:0] ex_pc_inc, branch_pc, jump_pc, taken_target, actual_next_pc;
    logic              resolve, actual_taken, ex_hit;
    cnt_state_e        cnt_upd;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^ex_instr[31:26];

    // Lookup
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];

    assign pred_taken = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][1];
    assign pred_pc    = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

    // Resolve
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[IDX_W+2 +: TAG_W];
    assign ex_pc_inc = ex_pc + PC_STEP;
    assign branch_pc = ex_pc_inc + (ex_branch_offset << 2);
    assign jump_pc   = {ex_pc_inc[DATA_W-1:28], ex_instr[25:0], 2'b00};

    // A jump wins when both type flags are set.
    assign resolve        = ex_valid && (ex_is_branch || ex_is_jump);
    assign actual_taken   = ex_is_jump || (ex_is_branch && ex_taken);
    assign taken_target   = ex_is_jump ? jump_pc : branch_pc;
    assign actual_next_pc = actual_taken ? taken_target : ex_pc_inc;

    assign redirect    = arst_n && resolve &&
                         ((actual_taken != ex_pred_taken) ||
                          (actual_taken && (ex_pred_pc != taken_target)));
    assign redirect_pc = actual_next_pc;

    assign mispredict_cnt = mcnt_q;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_counter2 u_sat_counter2 (
        .cnt_cur (cnt_q[ex_idx]),
        .hit     (ex_hit),
        .taken   (actual_taken),
        .is_jump (ex_is_jump),
        .cnt_nxt (cnt_upd)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (resolve) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = taken_target;
            cnt_d[ex_idx]    = cnt_upd;
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (redirect && (mcnt_q != {CNT_W{1'b1}})) mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
            mcnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter DATA_W, default 32, PC/data width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, number of predictor entries; power of two, 2..256.
REQ-003 Parameter TAG_W, default 8, stored PC tag bits per entry.
REQ-004 Parameter CNT_W, default 16, mispredict statistics counter width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 if_pc  in  DATA_W  fetch-stage PC to predict.
REQ-008 pred_taken  out  1  fetch prediction: redirect to target.
REQ-009 pred_pc  out  DATA_W  predicted next PC.
REQ-010 ex_valid  in  1  resolve-stage instruction valid.
REQ-011 ex_is_branch  in  1  resolving conditional branch.
REQ-012 ex_is_jump  in  1  resolving unconditional jump.
REQ-013 ex_pc  in  DATA_W  PC of the resolving instruction.
REQ-014 ex_instr  in  32  resolving instruction word.
REQ-015 ex_branch_offset  in  DATA_W  sign-extended branch immediate (words).
REQ-016 ex_taken  in  1  resolved branch condition.
REQ-017 ex_pred_taken  in  1  prediction carried with the instruction.
REQ-018 ex_pred_pc  in  DATA_W  predicted PC carried with the instruction.
REQ-019 redirect  out  1  mispredict: flush younger instructions.
REQ-020 redirect_pc  out  DATA_W  correct next PC on redirect.
REQ-021 mispredict_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-022 Index = if_pc[IDX_W+1:2], IDX_W = log2(BHT_DEPTH); tag = next TAG_W bits above the index; the resolve side indexes ex_pc identically.
REQ-023 Each entry: valid bit, tag, DATA_W target, 2-bit saturating counter.
REQ-024 Lookup is combinational: pred_taken = valid & tag match & counter[1]; pred_pc = stored target if pred_taken, else if_pc+4.
REQ-025 branch_pc = ex_pc+4 + (ex_branch_offset<<2), modulo 2^DATA_W.
REQ-026 jump_pc = {(ex_pc+4)[DATA_W-1:28], ex_instr[25:0], 2'b00}.
REQ-027 Actual next PC: jump -> jump_pc; branch taken -> branch_pc; else ex_pc+4.
REQ-028 redirect is combinational, asserted when ex_valid & (ex_is_branch|ex_is_jump) and (actual-taken != ex_pred_taken, or taken with ex_pred_pc != target); redirect_pc = actual next PC; redirect=0 otherwise.
REQ-029 Update on the clock edge when ex_valid & (branch|jump): write valid=1, tag, and target; counter increments on taken and decrements on not-taken, saturating at 3 and 0; a newly allocated entry (miss) loads 2 if taken, 1 if not; jumps load 3.
REQ-030 Same-cycle lookup and update of one index: lookup returns the pre-update entry (no bypass); the update is visible from the next cycle.
REQ-031 ex_is_branch and ex_is_jump both high: treat as jump.
REQ-032 mispredict_cnt increments once per cycle with redirect=1 and holds at all-ones.
REQ-033 ex_valid=0: no table update, no count, redirect=0.

Reset
REQ-034 On arst_n low, asynchronously clear all valid bits, set all counters to 1, clear targets, tags, and mispredict_cnt; outputs reset to pred_taken=0, pred_pc=if_pc+4, redirect=0.
REQ-035 Reset asserted mid-update discards the update; the first update is accepted on the first rising edge with arst_n high.

Structure
REQ-036 Counter encodings (SNT=0, WNT=1, WT=2, ST=3) and IDX_W derivation live in the shared CPU package.
REQ-037 The 2-bit saturating counter next-state function is a separate sub-module, sat_counter2.

Verification
REQ-038 After reset, if_pc=0x100 -> pred_taken=0, pred_pc=0x104.
REQ-039 Branch at ex_pc=0x100, offset=3, ex_taken=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x110; next cycle if_pc=0x100 -> pred_taken=1, pred_pc=0x110.
REQ-040 Same branch resolved not-taken three times from ST -> counter 3->2->1->0; predictions taken, taken, not-taken; mispredict_cnt stops at 0xFFFF only after 65535+ events.
REQ-041 Jump at ex_pc=0x2000_0000, instr[25:0]=0x40 -> redirect_pc=0x2000_0100; entry counter=3.
REQ-042 Aliasing: 0x100 and 0x100+4*BHT_DEPTH with different tags -> the second lookup misses until written, then overwrites.
REQ-043 arst_n pulsed low mid-update -> all entries invalid, mispredict_cnt=0, and no write observed.
